phv_action_aligner: RTL



---
 rtl/phv_action_aligner.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/phv_action_aligner.sv
// phv_action_aligner
//   Re-pairs each PHV with the action word that the match-action lookup
//   returns for it a few cycles later. The pair is then presented to the
//   stage crossbar from a single output register. PHVs and actions each
//   go through their own FIFO. Actions arrive in PHV order and cannot be
//   back-pressured. A watchdog releases a PHV whose action never comes,
//   and sends it out with an all-zero (pass-through) action.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   phv_in/_valid    PHV from key extractor; accepted when phv_ready_out
//   phv_ready_out    PHV FIFO not full (current count, ignores same-cycle pop)
//   action_in/_valid action from lookup, no backpressure
//   phv_out          registered PHV to crossbar
//   action_out       registered action to crossbar
//   out_valid        output register holds a pair
//   ready_in         crossbar may take the pair
//   phv_count        PHV FIFO occupancy
//   err_orphan       sticky: action arrived with no PHV waiting for it
//   err_timeout      sticky: watchdog released a PHV
module phv_action_aligner #(
  parameter int STAGE_ID   = 0,
  parameter int PHV_LEN    = 4*8*64+256,
  parameter int ACT_LEN    = 64,
  parameter int C_NUM_PHVS = 65,
  parameter int DEPTH      = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PHV_LEN-1:0]            phv_in,
  input  logic                          phv_in_valid,
  output logic                          phv_ready_out,
  input  logic [ACT_LEN*C_NUM_PHVS-1:0] action_in,
  input  logic                          action_in_valid,
  output logic [PHV_LEN-1:0]            phv_out,
  output logic [ACT_LEN*C_NUM_PHVS-1:0] action_out,
  output logic                          out_valid,
  input  logic                          ready_in,
  output logic [$clog2(DEPTH):0]        phv_count,
  output logic                          err_orphan,
  output logic                          err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int AL = ACT_LEN * C_NUM_PHVS;
  localparam int WW = $clog2(TIMEOUT) + 1;

  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);

  // The stage index only tags the instance; it is folded into the
  // elaboration check so that a bad configuration is rejected early.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || STAGE_ID < 0) begin : g_param_check
    $error("phv_action_aligner: illegal DEPTH/TIMEOUT/STAGE_ID");
  end

  logic [PHV_LEN-1:0] phv_mem [DEPTH];
  logic [AL-1:0]      act_mem [DEPTH];
  logic [AW-1:0]      phv_wp, phv_rp, act_wp, act_rp;
  logic [CW-1:0]      act_count;
  logic [CW-1:0]      discard_cnt;
  logic [WW-1:0]      wd_cnt;

  logic out_free, phv_push, pair_pop, wd_fire, phv_pop;
  logic act_push, act_orphan, act_disc, disc_inc;

  always_comb begin
    phv_ready_out = (phv_count != FULL);
    out_free      = !out_valid || ready_in;
    phv_push      = phv_in_valid && phv_ready_out;
    pair_pop      = (phv_count != '0) && (act_count != '0) && out_free;
    wd_fire       = (phv_count != '0) && (act_count == '0) && (wd_cnt == WD_MAX) && out_free;
    phv_pop       = pair_pop || wd_fire;

    // Actions for PHVs already released by the watchdog are dropped first.
    act_disc      = action_in_valid && (discard_cnt != '0);
    act_orphan    = action_in_valid && (discard_cnt == '0) &&
                    (act_count >= phv_count) && !phv_push;
    // An action that lands in the same cycle the watchdog fires belongs to
    // the PHV being released. It is dropped here and is not counted as a
    // later discard.
    act_push      = action_in_valid && (discard_cnt == '0) && !act_orphan && !wd_fire;
    disc_inc      = wd_fire && !(action_in_valid && (discard_cnt == '0));
  end

  // Storage arrays are not reset. The pointers and counts alone decide
  // which entries are valid.
  always_ff @(posedge clk) begin
    if (phv_push) phv_mem[phv_wp] <= phv_in;
    if (act_push) act_mem[act_wp] <= action_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phv_wp      <= '0;
      phv_rp      <= '0;
      act_wp      <= '0;
      act_rp      <= '0;
      phv_count   <= '0;
      act_count   <= '0;
      discard_cnt <= '0;
      wd_cnt      <= '0;
      out_valid   <= 1'b0;
      phv_out     <= '0;
      action_out  <= '0;
      err_orphan  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (phv_push) phv_wp <= phv_wp + AW'(1);
      if (phv_pop)  phv_rp <= phv_rp + AW'(1);
      if (act_push) act_wp <= act_wp + AW'(1);
      if (pair_pop) act_rp <= act_rp + AW'(1);
      phv_count <= phv_count + CW'(phv_push) - CW'(phv_pop);
      act_count <= act_count + CW'(act_push) - CW'(pair_pop);

      if (disc_inc && !act_disc && discard_cnt != FULL) discard_cnt <= discard_cnt + CW'(1);
      else if (act_disc && !disc_inc)                   discard_cnt <= discard_cnt - CW'(1);

      // Count only while a PHV waits on an empty action FIFO. Hold at the
      // limit so that a blocked output register fires on the first free cycle.
      if (phv_pop || act_count != '0 || phv_count == '0) wd_cnt <= '0;
      else if (wd_cnt != WD_MAX)                         wd_cnt <= wd_cnt + WW'(1);

      if (pair_pop) begin
        out_valid  <= 1'b1;
        phv_out    <= phv_mem[phv_rp];
        action_out <= act_mem[act_rp];
      end else if (wd_fire) begin
        out_valid  <= 1'b1;
        phv_out    <= phv_mem[phv_rp];
        action_out <= '0;
      end else if (ready_in) begin
        out_valid  <= 1'b0;
      end

      if (act_orphan) err_orphan  <= 1'b1;
      if (wd_fire)    err_timeout <= 1'b1;
    end
  end

endmodule
